// File: rtl/fetch_stage.sv
// fetch_stage -- IF stage of a 5-stage pipeline: PC register, IF/ID register,
// and a RUN/HALTED FSM that parks the front end after ECALL/EBREAK.
//
// Ports:
//   clk            in   clock; all state updates on the rising edge
//   rst            in   synchronous reset, active low
//   stall          in   hold PC and IF/ID (hazard unit)
//   branch_taken   in   redirect from EX; beats stall and HALTED
//   branch_target  in   redirect address; bit 0 is forced to 0
//   instr_in       in   instruction word read combinationally at pc_out
//   pc_out         out  current fetch address
//   ifid_pc        out  IF/ID: PC of held instruction
//   ifid_pc4       out  IF/ID: ifid_pc + 4
//   ifid_instr     out  IF/ID: held instruction word
//   ifid_valid     out  IF/ID holds a real instruction (0 = bubble)
//   halted         out  FSM is in HALTED
//   perf_fetch_cnt out  instructions latched into IF/ID
//   perf_flush_cnt out  redirects taken
//
// Build option: define FETCH_PERF_CNT_EN to enable the two performance
// counters. When undefined the counter ports are tied to 0 and no counter
// flops exist.
module fetch_stage #(
  parameter int           N        = 32,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         branch_taken,
  input  logic [N-1:0] branch_target,
  input  logic [31:0]  instr_in,
  output logic [N-1:0] pc_out,
  output logic [N-1:0] ifid_pc,
  output logic [N-1:0] ifid_pc4,
  output logic [31:0]  ifid_instr,
  output logic         ifid_valid,
  output logic         halted,
  output logic [31:0]  perf_fetch_cnt,
  output logic [31:0]  perf_flush_cnt
);

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  typedef struct packed {
    logic [N-1:0] pc;
    logic [N-1:0] pc4;
    logic [31:0]  instr;
    logic         valid;
  } ifid_t;

  state_t       state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  ifid_t        ifid_q, ifid_d;

  logic [N-1:0] pc_plus4;
  logic         is_halt;
  logic         fetch_en;

  // Redirect targets are halfword aligned; bit 0 is dropped on purpose.
  logic unused_tgt_lsb;
  assign unused_tgt_lsb = branch_target[0];

  assign pc_plus4 = pc_q + N'(4);
  assign is_halt  = (instr_in == ECALL) || (instr_in == EBREAK);
  // An instruction is latched into IF/ID on this edge (normal or halting fetch).
  assign fetch_en = !branch_taken && (state_q == RUN) && !stall;

  // Priority: branch > HALTED hold > stall > fetch (reset handled in the flop).
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ifid_d  = ifid_q;
    if (branch_taken) begin
      // Flush: squash the IF/ID instruction but keep its PC fields.
      pc_d         = {branch_target[N-1:1], 1'b0};
      ifid_d.instr = NOP;
      ifid_d.valid = 1'b0;
      state_d      = RUN;
    end else if (state_q == HALTED) begin
      ifid_d.instr = NOP;
      ifid_d.valid = 1'b0;
    end else if (!stall) begin
      ifid_d.pc    = pc_q;
      ifid_d.pc4   = pc_plus4;
      ifid_d.instr = instr_in;
      ifid_d.valid = 1'b1;
      // The halting instruction itself goes down the pipe; PC stays on it.
      if (is_halt) state_d = HALTED;
      else         pc_d    = pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      ifid_q  <= '{pc: '0, pc4: '0, instr: NOP, valid: 1'b0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
    end
  end

  assign pc_out     = pc_q;
  assign ifid_pc    = ifid_q.pc;
  assign ifid_pc4   = ifid_q.pc4;
  assign ifid_instr = ifid_q.instr;
  assign ifid_valid = ifid_q.valid;
  assign halted     = (state_q == HALTED);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (fetch_en)     fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (branch_taken) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  logic unused_fetch_en;
  assign unused_fetch_en = fetch_en;
  assign perf_fetch_cnt  = '0;
  assign perf_flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst, stall, branch_taken;
  logic [31:0] branch_target, instr_in;
  logic [31:0] pc_out, ifid_pc, ifid_pc4, ifid_instr;
  logic        ifid_valid, halted;
  logic [31:0] perf_fetch_cnt, perf_flush_cnt;

  logic [31:0] w_pc, w_ifid_pc, w_ifid_pc4, w_ifid_instr, w_fcnt, w_flcnt;
  logic        w_valid, w_halted;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .instr_in(instr_in), .pc_out(pc_out),
    .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4), .ifid_instr(ifid_instr),
    .ifid_valid(ifid_valid), .halted(halted),
    .perf_fetch_cnt(perf_fetch_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  // Second instance parked at the top of the address space to show PC wrap.
  fetch_stage #(.N(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .stall(1'b0), .branch_taken(1'b0),
    .branch_target(32'h0), .instr_in(NOP), .pc_out(w_pc),
    .ifid_pc(w_ifid_pc), .ifid_pc4(w_ifid_pc4), .ifid_instr(w_ifid_instr),
    .ifid_valid(w_valid), .halted(w_halted),
    .perf_fetch_cnt(w_fcnt), .perf_flush_cnt(w_flcnt)
  );

  typedef struct {
    logic [31:0] pc, ipc, ipc4, instr, fcnt, flcnt;
    logic        valid, halted;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0, n_total = 0;

  // Reference state of the fetch stage, advanced once per step.
  logic [31:0] m_pc = 0, m_ipc = 0, m_ipc4 = 0, m_instr = NOP, m_fcnt = 0, m_flcnt = 0;
  logic        m_valid = 0, m_halted = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step(input logic r, input logic st, input logic br,
                      input logic [31:0] tgt, input logic [31:0] ins);
    exp_t e;
    @(negedge clk);
    rst = r; stall = st; branch_taken = br; branch_target = tgt; instr_in = ins;
    if (!r) begin
      m_pc = 32'h0; m_ipc = 0; m_ipc4 = 0; m_instr = NOP; m_valid = 0;
      m_halted = 0; m_fcnt = 0; m_flcnt = 0;
    end else if (br) begin
      m_pc = {tgt[31:1], 1'b0}; m_instr = NOP; m_valid = 0; m_halted = 0;
      m_flcnt++;
    end else if (m_halted) begin
      m_instr = NOP; m_valid = 0;
    end else if (!st) begin
      m_ipc = m_pc; m_ipc4 = m_pc + 4; m_instr = ins; m_valid = 1; m_fcnt++;
      if (ins == ECALL || ins == EBREAK) m_halted = 1;
      else m_pc = m_pc + 4;
    end
    e.pc = m_pc; e.ipc = m_ipc; e.ipc4 = m_ipc4; e.instr = m_instr;
    e.valid = m_valid; e.halted = m_halted;
`ifdef FETCH_PERF_CNT_EN
    e.fcnt = m_fcnt; e.flcnt = m_flcnt;
`else
    e.fcnt = 0; e.flcnt = 0;
`endif
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("pc_out",     pc_out,             e.pc);
    chk("ifid_pc",    ifid_pc,            e.ipc);
    chk("ifid_pc4",   ifid_pc4,           e.ipc4);
    chk("ifid_instr", ifid_instr,         e.instr);
    chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, e.valid});
    chk("halted",     {31'b0, halted},     {31'b0, e.halted});
    chk("fetch_cnt",  perf_fetch_cnt,     e.fcnt);
    chk("flush_cnt",  perf_flush_cnt,     e.flcnt);
  endtask

  initial begin
    rst = 0; stall = 0; branch_taken = 0; branch_target = 0; instr_in = NOP;
    // Reset while a branch and a stall are both requested.
    step(0, 1, 1, 32'h0000_0044, NOP);
    chk("wrap_reset_pc", w_pc, 32'hFFFF_FFFC);
    // Four free cycles of NOPs.
    step(1, 0, 0, 0, NOP);
    chk("wrap_next_pc", w_pc, 32'h0000_0000);
    chk("wrap_valid",   {31'b0, w_valid}, 32'h1);
    repeat (3) step(1, 0, 0, 0, NOP);
    chk("free_pc16", pc_out, 32'd16);
    // Restart, run to pc 8, stall three cycles, resume.
    step(0, 0, 0, 0, NOP);
    repeat (2) step(1, 0, 0, 0, NOP);
    repeat (3) step(1, 1, 0, 0, 32'hDEAD_BEEF);
    chk("stall_pc8", pc_out, 32'd8);
    repeat (3) step(1, 0, 0, 0, NOP);
    chk("resume_pc20", pc_out, 32'd20);
    // EBREAK at pc 20 halts; bubbles follow regardless of stall.
    step(1, 0, 0, 0, EBREAK);
    chk("ebreak_latched", ifid_instr, EBREAK);
    step(1, 1, 0, 0, NOP);
    step(1, 0, 0, 0, 32'h0000_0093);
    chk("halt_pc20", pc_out, 32'd20);
    // Branch out of HALTED, then fetch from 40.
    step(1, 0, 1, 32'd40, NOP);
    step(1, 0, 0, 0, 32'h0000_0113);
    chk("post_halt_ipc", ifid_pc, 32'd40);
    // Branch beats stall; odd target is aligned.
    step(1, 1, 1, 32'h0000_0101, NOP);
    chk("branch_align", pc_out, 32'h0000_0100);
    // Reset while stalled.
    step(1, 1, 0, 0, NOP);
    step(0, 1, 0, 0, NOP);
    // Halt on ECALL, then reset from HALTED.
    step(1, 0, 0, 0, NOP);
    step(1, 0, 0, 0, ECALL);
    chk("ecall_halt", {31'b0, halted}, 32'h1);
    step(0, 0, 0, 0, NOP);
    step(1, 0, 0, 0, NOP);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
